// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle RV32 subset control unit (Moore FSM, 12 states)
module mc_ctrl #(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       z,
    output logic       pc_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic [1:0] imm_src,
    output logic       retire,
    output logic       halted
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    state_t r_state;
    state_t w_next;
    state_t w_illegal_next;

    logic [2:0] w_alu_dec;
    logic       w_f3_ok;
    logic       w_pc_write;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_retire;

    assign w_illegal_next = ILLEGAL_HALT ? S_HALT : S_FETCH;

    // funct3 decode for the ALU states; w_f3_ok flags the supported subset
    always_comb begin
        w_alu_dec = ALU_ADD;
        w_f3_ok   = 1'b1;
        case (funct3)
            3'b000:  w_alu_dec = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  w_alu_dec = ALU_SLT;
            3'b110:  w_alu_dec = ALU_OR;
            3'b111:  w_alu_dec = ALU_AND;
            default: w_f3_ok   = 1'b0;
        endcase
    end

    always_comb begin
        imm_src = 2'b00;
        case (op)
            OP_LW, OP_I: imm_src = 2'b00;
            OP_SW:       imm_src = 2'b01;
            OP_BEQ:      imm_src = 2'b10;
            OP_JAL:      imm_src = 2'b11;
            default:     imm_src = 2'b00;
        endcase
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECR;
                    OP_I:         w_next = S_EXECI;
                    OP_JAL:       w_next = S_JAL;
                    OP_BEQ:       w_next = S_BEQ;
                    default:      w_next = w_illegal_next;
                endcase
            end
            S_MEMADR:   w_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = S_FETCH;
            S_EXECR:    w_next = w_f3_ok ? S_ALUWB : w_illegal_next;
            S_EXECI:    w_next = w_f3_ok ? S_ALUWB : w_illegal_next;
            S_ALUWB:    w_next = S_FETCH;
            S_JAL:      w_next = S_ALUWB;
            S_BEQ:      w_next = S_FETCH;
            S_HALT:     w_next = S_HALT;
            default:    w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        w_retire    = 1'b0;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_ctrl    = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_ir_write = 1'b1;
                w_pc_write = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                w_mem_write = 1'b1;
                w_retire    = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_ctrl  = w_alu_dec;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_ctrl  = w_alu_dec;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
            end
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                w_pc_write = 1'b1;
            end
            S_BEQ: begin
                alu_src_a  = 2'b10;
                alu_ctrl   = ALU_SUB;
                w_pc_write = z;
                w_retire   = 1'b1;
            end
            default: ;
        endcase
    end

    // The state register resets asynchronously to FETCH, whose enables are
    // live; gating with rst_n keeps every enable low while reset is held.
    assign pc_write  = w_pc_write  & rst_n;
    assign ir_write  = w_ir_write  & rst_n;
    assign mem_write = w_mem_write & rst_n;
    assign reg_write = w_reg_write & rst_n;
    assign retire    = w_retire    & rst_n;
    assign halted    = (r_state == S_HALT) & rst_n;

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter ILLEGAL_HALT, default 1: 1 = illegal instruction parks the FSM in HALT until reset; 0 = illegal instruction is treated as a NOP and the FSM returns to FETCH.
REQ-002 Port clk, input, 1: single clock, all state updates on the rising edge.
REQ-003 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 Port op, input, 7: opcode, instr[6:0], taken from the instruction register.
REQ-005 Port funct3, input, 3: instr[14:12].
REQ-006 Port funct7b5, input, 1: instr[30].
REQ-007 Port z, input, 1: ALU zero flag.
REQ-008 Port pc_write, output, 1: PC register load enable.
REQ-009 Port adr_src, output, 1: memory address select; 0 = PC, 1 = ALU result register.
REQ-010 Port ir_write, output, 1: instruction register load enable.
REQ-011 Port mem_write, output, 1: data memory write enable.
REQ-012 Port reg_write, output, 1: register file write enable.
REQ-013 Port result_src, output, 2: result select; 00 = ALU result register, 01 = memory data, 10 = live ALU output.
REQ-014 Port alu_src_a, output, 2: ALU operand A select; 00 = PC, 01 = old PC, 10 = rs1.
REQ-015 Port alu_src_b, output, 2: ALU operand B select; 00 = rs2, 01 = immediate, 10 = constant 4.
REQ-016 Port alu_ctrl, output, 3: ALU operation; 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-017 Port imm_src, output, 2: immediate format; 00 = I, 01 = S, 10 = B, 11 = J.
REQ-018 Port retire, output, 1: one-cycle pulse in the final state of each completed instruction.
REQ-019 Port halted, output, 1: high while the FSM is in HALT.

Function
REQ-020 Moore FSM with 12 states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BEQ, HALT. The state register is the only sequential element.
REQ-021 Outputs are combinational from state and instruction fields; any output not listed for a state is 0.
REQ-022 FETCH: ir_write=1, pc_write=1, adr_src=0, src_a=00, src_b=10, alu add, result_src=10. Next state DECODE.
REQ-023 DECODE: src_a=01, src_b=01, alu add (branch/jump target). Next state by op:
- 0000011 (lw) or 0100011 (sw) -> MEMADR
- 0110011 (R-type) -> EXECR
- 0010011 (I-ALU) -> EXECI
- 1101111 (jal) -> JAL
- 1100011 (beq) -> BEQ
- any other op -> illegal
REQ-024 MEMADR: src_a=10, src_b=01, alu add. Next state MEMREAD for lw, MEMWRITE for sw.
REQ-025 MEMREAD: adr_src=1, result_src=00. Next state MEMWB.
REQ-026 MEMWB: result_src=01, reg_write=1, retire=1. Next state FETCH.
REQ-027 MEMWRITE: adr_src=1, result_src=00, mem_write=1, retire=1. Next state FETCH.
REQ-028 EXECR: src_a=10, src_b=00, alu_ctrl decoded. Next state ALUWB.
REQ-029 EXECI: src_a=10, src_b=01, alu_ctrl decoded. Next state ALUWB.
REQ-030 ALUWB: result_src=00, reg_write=1, retire=1. Next state FETCH.
REQ-031 JAL: src_a=01, src_b=10, alu add, result_src=00, pc_write=1. Next state ALUWB (writes rd = old PC + 4).
REQ-032 BEQ: src_a=10, src_b=00, alu sub, result_src=00, pc_write=z, retire=1. Next state FETCH.
REQ-033 ALU decode in EXECR/EXECI, by funct3:
- 000: sub only when R-type and funct7b5=1; add otherwise
- 010: slt
- 110: or
- 111: and
- any other funct3: illegal
REQ-034 imm_src decoded from op in every state: I for lw and I-ALU, S for sw, B for beq, J for jal, 00 otherwise.
REQ-035 Illegal instruction, ILLEGAL_HALT=1: next state HALT; no enable asserts in the detecting cycle; HALT holds all enables at 0 and halted=1 until reset.
REQ-036 Illegal instruction, ILLEGAL_HALT=0: next state FETCH; no register or memory write; retire=0.
REQ-037 Cycles per instruction: lw 5, sw 4, R/I 4, jal 4, beq 3.

Reset
REQ-038 While rst_n=0, state is FETCH and pc_write, ir_write, mem_write, reg_write, retire and halted are forced to 0; mux selects show their FETCH values.
REQ-039 Reset asserted mid-instruction aborts the instruction immediately (asynchronously), with no retire.
REQ-040 The first rising edge after rst_n rises executes FETCH normally.

Verification
REQ-041 add x3,x1,x2 (op=0110011, f3=000, f7b5=0): states FETCH,DECODE,EXECR,ALUWB; alu_ctrl=000 in EXECR; reg_write=1 and retire=1 in cycle 4.
REQ-042 sub and slt: f7b5=1, f3=000 -> alu_ctrl=001; f3=010 -> 101. ori (op=0010011, f3=110) -> 011 with src_b=01.
REQ-043 lw then sw: lw gives mem_write=0 and reg_write=1 only in cycle 5 with result_src=01; sw gives mem_write=1, adr_src=1 in cycle 4 and no reg_write.
REQ-044 beq: z=1 -> pc_write=1 in BEQ; z=0 -> pc_write=0; both return to FETCH after 3 cycles.
REQ-045 op=1111111: ILLEGAL_HALT=1 -> halted=1 from cycle 3 with all enables 0 for 20+ cycles; ILLEGAL_HALT=0 -> back to FETCH in cycle 3, retire never pulses.
REQ-046 rst_n pulsed low during MEMREAD: all enables drop to 0 within the same cycle; after release, FETCH with ir_write=1.
